lpgbt_downlink_frame_builder: RTL and testbench
===============================================

# lpgbt_downlink_frame_builder

Transmit-side companion to the lpGBT uplink receiver. It buffers 32-bit downlink user words written by software through the register interface and presents one lpGBT downlink frame per 40 MHz frame strobe. Each frame carries 32 user bits, 2 IC bits and 2 EC bits, and is handed to the downlink encoder/MGT path. It provides fill-threshold start, idle substitution on underrun, and status counters for AXI readback.

## Interface
- FIFO_DEPTH, 16: user-word buffer depth; power of two, ≥4.
- START_THRESHOLD, 4: FIFO level required before the first pop after enable/flush; 1..FIFO_DEPTH.
- IDLE_WORD, 32'h0000_0000: user word sent when no FIFO data is sent.
- S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- fifo_wdata_i  in  32  downlink user word to enqueue.
- fifo_wen_i  in  1  push strobe, one word per cycle high.
- frame_strobe_i  in  1  one-cycle pulse per 40 MHz frame boundary, already synchronous to S_AXI_ACLK.
- enable_i  in  1  level; 1 = stream FIFO data, 0 = idle frames only.
- flush_i  in  1  pulse; empties FIFO.
- ic_i  in  2  IC field, sampled on frame_strobe_i.
- ec_i  in  2  EC field, sampled on frame_strobe_i.
- clear_status_i  in  1  pulse; clears overflow_o and underrun_count_o.
- downlinkUserData_o  out  32  current frame user data.
- downlinkIcData_o  out  2  current frame IC bits.
- downlinkEcData_o  out  2  current frame EC bits.
- downlinkValid_o  out  1  one-cycle pulse when a new frame is loaded.
- downlinkFromFifo_o  out  1  1 = current user word came from FIFO, 0 = IDLE_WORD.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  words stored.
- fifo_empty_o / fifo_full_o  out  1 each  level==0 / level==FIFO_DEPTH.
- overflow_o  out  1  sticky: a push was dropped.
- underrun_count_o  out  16  saturating count of frames sent idle while in RUN.

## Operation
- Reset values:
  - downlinkUserData_o = IDLE_WORD; downlinkIcData_o = downlinkEcData_o = 2'b11.
  - downlinkValid_o = 0, downlinkFromFifo_o = 0.
  - fifo_level_o = 0, fifo_empty_o = 1, fifo_full_o = 0.
  - overflow_o = 0, underrun_count_o = 0.
  - FIFO pointers = 0, state = DISABLED.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits; pointers wrap modulo FIFO_DEPTH.
  - A push is accepted iff fifo_full_o is 0 (registered level).
  - A push while full is dropped and sets overflow_o.
  - Push and pop in the same cycle: both occur, level unchanged.
- State machine:
  - DISABLED: go to WAIT_FILL when enable_i = 1.
  - WAIT_FILL: on frame_strobe_i, if level ≥ START_THRESHOLD, pop this frame and go to RUN; otherwise send IDLE_WORD with no underrun count.
  - RUN: on each frame_strobe_i, pop if non-empty. If empty, send IDLE_WORD and increment underrun_count_o, saturating at 16'hFFFF.
  - From any state, enable_i = 0 goes to DISABLED next cycle. FIFO contents are kept; frames are IDLE_WORD.
- Every frame_strobe_i, in every state, loads a frame: user word, ic_i, ec_i, downlinkFromFifo_o, and pulses downlinkValid_o.
- flush_i:
  - Resets pointers and level to 0.
  - State goes to WAIT_FILL if enable_i = 1, else DISABLED.
  - Same-cycle push is discarded without setting overflow.
  - Same-cycle frame_strobe_i sends IDLE_WORD.
- clear_status_i with a same-cycle overflow or underrun event: the event wins (overflow_o = 1, or count = 1).
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous); FIFO data is lost.

## Timing
- frame_strobe_i high at edge N: frame outputs and downlinkValid_o update at edge N (visible in cycle N+1). downlinkValid_o is high for exactly that cycle.
- Push at edge N: word is poppable by a strobe at edge N+1.
- Level, empty and full flags are registered and reflect all push/pop/flush activity at edge N in cycle N+1.
- Frame outputs hold between strobes; strobes may arrive at any spacing ≥1 cycle.

## Test plan
- Reset, then 3 strobes with enable_i = 0 -> downlinkUserData_o = 0x00000000 each frame, downlinkValid_o 3 single pulses, IC/EC follow ic_i/ec_i.
- enable_i = 1, push 0x11111111..0x44444444, then 6 strobes -> frames 1–4 carry the pushed words in order with downlinkFromFifo_o = 1; frames 5–6 are IDLE_WORD; underrun_count_o = 2.
- enable_i = 1, push 3 words, strobe -> IDLE_WORD, state stays WAIT_FILL; push a 4th, strobe -> first pushed word sent.
- Push 17 words into a depth-16 FIFO -> fifo_full_o = 1, overflow_o = 1, level 16; 16 strobes return words 1–16; word 17 is absent.
- With full FIFO, assert push and strobe in the same cycle -> pop occurs, push dropped, level 15, overflow_o = 1; then a push and pop on the same cycle at level 8 -> level stays 8.
- Assert flush_i together with fifo_wen_i and frame_strobe_i -> level 0, IDLE_WORD sent, overflow_o unchanged. Drive 70000 underruns -> count saturates at 0xFFFF. clear_status_i -> 0.

Source files
------------

// File: rtl/lpgbt_downlink_frame_builder.sv
// lpGBT downlink frame builder: buffers software-written 32-bit user words and
// emits one frame (user word + IC + EC) per frame strobe, with fill-threshold start.
module lpgbt_downlink_frame_builder #(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned START_THRESHOLD = 4,
  parameter logic [31:0] IDLE_WORD       = 32'h0000_0000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [31:0]                     fifo_wdata_i,
  input  logic                            fifo_wen_i,
  input  logic                            frame_strobe_i,
  input  logic                            enable_i,
  input  logic                            flush_i,
  input  logic [1:0]                      ic_i,
  input  logic [1:0]                      ec_i,
  input  logic                            clear_status_i,
  output logic [31:0]                     downlinkUserData_o,
  output logic [1:0]                      downlinkIcData_o,
  output logic [1:0]                      downlinkEcData_o,
  output logic                            downlinkValid_o,
  output logic                            downlinkFromFifo_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            fifo_empty_o,
  output logic                            fifo_full_o,
  output logic                            overflow_o,
  output logic [15:0]                     underrun_count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] THRESH_LVL = LVL_W'(START_THRESHOLD);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_WAIT_FILL,
    ST_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        underrun_q, underrun_d;
  logic [31:0]        user_q, user_d;
  logic [1:0]         ic_q, ic_d;
  logic [1:0]         ec_q, ec_d;
  logic               valid_q, valid_d;
  logic               from_fifo_q, from_fifo_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic streaming, push, drop, pop, underrun;

  // NOTE: every signal assigned here gets a default first, so no path can leave a latch.
  always_comb begin
    streaming = enable_i && (state_q != ST_DISABLED) && !flush_i;
    push      = fifo_wen_i && !full_q && !flush_i;
    drop      = fifo_wen_i &&  full_q && !flush_i;
    pop       = frame_strobe_i && streaming &&
                (((state_q == ST_WAIT_FILL) && (level_q >= THRESH_LVL)) ||
                 ((state_q == ST_RUN) && !empty_q));
    underrun  = frame_strobe_i && streaming && (state_q == ST_RUN) && empty_q;

    state_d = state_q;
    if (!enable_i)    state_d = ST_DISABLED;
    else if (flush_i) state_d = ST_WAIT_FILL;
    else begin
      case (state_q)
        ST_DISABLED:  state_d = ST_WAIT_FILL;
        ST_WAIT_FILL: if (pop) state_d = ST_RUN;
        default:      state_d = ST_RUN;
      endcase
    end

    wr_ptr_d = flush_i ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + PTR_W'(pop);
    level_d  = flush_i ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
    empty_d  = (level_d == '0);
    full_d   = (level_d == FULL_LVL);

    // A same-cycle event beats clear_status_i so no dropped push or idle frame goes unseen.
    overflow_d = drop ? 1'b1 : (clear_status_i ? 1'b0 : overflow_q);
    underrun_d = clear_status_i ? 16'd0 : underrun_q;
    if (underrun && (underrun_d != 16'hFFFF)) underrun_d = underrun_d + 16'd1;

    user_d      = user_q;
    ic_d        = ic_q;
    ec_d        = ec_q;
    from_fifo_d = from_fifo_q;
    valid_d     = frame_strobe_i;
    if (frame_strobe_i) begin
      user_d      = pop ? mem_q[rd_ptr_q] : IDLE_WORD;
      ic_d        = ic_i;
      ec_d        = ec_i;
      from_fifo_d = pop;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= ST_DISABLED;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 16'd0;
      user_q      <= IDLE_WORD;
      ic_q        <= 2'b11;
      ec_q        <= 2'b11;
      valid_q     <= 1'b0;
      from_fifo_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
      user_q      <= user_d;
      ic_q        <= ic_d;
      ec_q        <= ec_d;
      valid_q     <= valid_d;
      from_fifo_q <= from_fifo_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; a word is only read behind a non-zero level.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= fifo_wdata_i;
  end

  assign downlinkUserData_o = user_q;
  assign downlinkIcData_o   = ic_q;
  assign downlinkEcData_o   = ec_q;
  assign downlinkValid_o    = valid_q;
  assign downlinkFromFifo_o = from_fifo_q;
  assign fifo_level_o       = level_q;
  assign fifo_empty_o       = empty_q;
  assign fifo_full_o        = full_q;
  assign overflow_o         = overflow_q;
  assign underrun_count_o   = underrun_q;

endmodule

// File: tb/tb_lpgbt_downlink_frame_builder.sv
// Scoreboard bench: stimulus drives a queue-based reference model and queues
// expected frames; a negedge monitor compares every downlinkValid_o pulse.
module tb_lpgbt_downlink_frame_builder;

  localparam int          DEPTH = 16;
  localparam int          THRESH = 4;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fifo_wdata_i = '0;
  logic        fifo_wen_i = 1'b0;
  logic        frame_strobe_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  ic_i = '0;
  logic [1:0]  ec_i = '0;
  logic        clear_status_i = 1'b0;
  logic [31:0] downlinkUserData_o;
  logic [1:0]  downlinkIcData_o;
  logic [1:0]  downlinkEcData_o;
  logic        downlinkValid_o;
  logic        downlinkFromFifo_o;
  logic [4:0]  fifo_level_o;
  logic        fifo_empty_o;
  logic        fifo_full_o;
  logic        overflow_o;
  logic [15:0] underrun_count_o;

  lpgbt_downlink_frame_builder #(
    .FIFO_DEPTH(DEPTH), .START_THRESHOLD(THRESH), .IDLE_WORD(IDLE)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .fifo_wdata_i(fifo_wdata_i), .fifo_wen_i(fifo_wen_i),
    .frame_strobe_i(frame_strobe_i), .enable_i(enable_i), .flush_i(flush_i),
    .ic_i(ic_i), .ec_i(ec_i), .clear_status_i(clear_status_i),
    .downlinkUserData_o(downlinkUserData_o), .downlinkIcData_o(downlinkIcData_o),
    .downlinkEcData_o(downlinkEcData_o), .downlinkValid_o(downlinkValid_o),
    .downlinkFromFifo_o(downlinkFromFifo_o), .fifo_level_o(fifo_level_o),
    .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
    .overflow_o(overflow_o), .underrun_count_o(underrun_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] user;
    logic [1:0]  ic;
    logic [1:0]  ec;
    logic        from_fifo;
  } frame_t;

  frame_t      sb[$];
  logic [31:0] m_fifo[$];
  int          m_mode;      // 0 disabled, 1 waiting for fill, 2 running
  logic        m_ovf;
  int          m_und;
  logic        en;
  int          checks, errors, strobes_sent, pulses_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && downlinkValid_o) begin
      frame_t f;
      pulses_seen++;
      if (sb.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        f = sb.pop_front();
        check("frame.user", downlinkUserData_o, f.user);
        check("frame.ic", 32'(downlinkIcData_o), 32'(f.ic));
        check("frame.ec", 32'(downlinkEcData_o), 32'(f.ec));
        check("frame.from_fifo", 32'(downlinkFromFifo_o), 32'(f.from_fifo));
      end
    end
  end

  // One clock: drive inputs, advance the reference model, wait for the edge.
  task automatic step(input logic wen, input logic [31:0] wd, input logic strb,
                      input logic fl, input logic clr);
    bit     full, streaming, pop, und, drop;
    frame_t f;
    fifo_wen_i     = wen;
    fifo_wdata_i   = wd;
    frame_strobe_i = strb;
    flush_i        = fl;
    clear_status_i = clr;
    enable_i       = en;
    ic_i           = 2'($urandom);
    ec_i           = 2'($urandom);

    full      = (m_fifo.size() == DEPTH);
    streaming = en && (m_mode != 0) && !fl;
    pop       = strb && streaming &&
                ((m_mode == 1 && m_fifo.size() >= THRESH) || (m_mode == 2 && m_fifo.size() > 0));
    und       = strb && streaming && (m_mode == 2) && (m_fifo.size() == 0);
    drop      = wen && full && !fl;

    if (strb) begin
      f.user      = pop ? m_fifo[0] : IDLE;
      f.ic        = ic_i;
      f.ec        = ec_i;
      f.from_fifo = pop;
      sb.push_back(f);
      strobes_sent++;
    end

    if (fl) m_fifo.delete();
    else begin
      if (pop) void'(m_fifo.pop_front());
      if (wen && !full) m_fifo.push_back(wd);
    end
    if (clr) begin m_ovf = 1'b0; m_und = 0; end
    if (drop) m_ovf = 1'b1;
    if (und && m_und != 65535) m_und++;

    if (!en)                       m_mode = 0;
    else if (fl)                   m_mode = 1;
    else if (m_mode == 0)          m_mode = 1;
    else if (m_mode == 1 && pop)   m_mode = 2;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_status(input string tag);
    check({tag, ".level"}, 32'(fifo_level_o), 32'(m_fifo.size()));
    check({tag, ".empty"}, 32'(fifo_empty_o), 32'(m_fifo.size() == 0));
    check({tag, ".full"}, 32'(fifo_full_o), 32'(m_fifo.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow_o), 32'(m_ovf));
    check({tag, ".underrun"}, 32'(underrun_count_o), 32'(m_und));
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_mode = 0;
    m_ovf  = 1'b0;
    m_und  = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    check({tag, ".user"}, downlinkUserData_o, IDLE);
    check({tag, ".ic"}, 32'(downlinkIcData_o), 32'd3);
    check({tag, ".ec"}, 32'(downlinkEcData_o), 32'd3);
    check({tag, ".valid"}, 32'(downlinkValid_o), 32'd0);
    check({tag, ".from_fifo"}, 32'(downlinkFromFifo_o), 32'd0);
    check({tag, ".level"}, 32'(fifo_level_o), 32'd0);
    check({tag, ".empty"}, 32'(fifo_empty_o), 32'd1);
    check({tag, ".full"}, 32'(fifo_full_o), 32'd0);
    check({tag, ".overflow"}, 32'(overflow_o), 32'd0);
    check({tag, ".underrun"}, 32'(underrun_count_o), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    model_reset();
    en = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;

    // Disabled: idle frames, IC/EC follow inputs
    for (int i = 0; i < 3; i++) begin step(1'b0, 0, 1'b1, 1'b0, 1'b0); idle(1); end
    chk_status("disabled");

    // Basic stream with underrun
    en = 1'b1;
    idle(1);
    for (int i = 1; i <= 4; i++) step(1'b1, 32'h1111_1111 * i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin step(1'b0, 0, 1'b1, 1'b0, 1'b0); idle(1); end
    check("und_after_drain", 32'(underrun_count_o), 32'd2);
    chk_status("stream");

    // Threshold start
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0003, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk_status("thresh");
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Overflow: 17 pushes
    for (int i = 1; i <= 17; i++) step(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, 1'b0);
    check("ovf.full", 32'(fifo_full_o), 32'd1);
    check("ovf.level", 32'(fifo_level_o), 32'd16);
    check("ovf.flag", 32'(overflow_o), 32'd1);
    step(1'b1, 32'hB000_0012, 1'b1, 1'b0, 1'b0);
    check("full_push_pop.level", 32'(fifo_level_o), 32'd15);
    chk_status("full_push_pop");
    for (int i = 0; i < 15; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC000_0008, 1'b1, 1'b0, 1'b0);
    check("push_pop_l8.level", 32'(fifo_level_o), 32'd8);

    // Flush with same-cycle push and strobe
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    check("flush.level", 32'(fifo_level_o), 32'd0);
    check("flush.ovf_kept", 32'(overflow_o), 32'd1);
    chk_status("flush");

    // Underrun saturation
    for (int i = 0; i < 4; i++) step(1'b1, 32'hE000_0000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("und_sat", 32'(underrun_count_o), 32'hFFFF);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("clear.und", 32'(underrun_count_o), 32'd0);
    check("clear.ovf", 32'(overflow_o), 32'd0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("clear_vs_und", 32'(underrun_count_o), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    check("clear_vs_ovf", 32'(overflow_o), 32'd1);
    chk_status("clear_events");
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) en = ~en;
      step(1'($urandom_range(1) == 0), $urandom, 1'($urandom_range(9) < 3),
           1'($urandom_range(49) == 0), 1'($urandom_range(49) == 0));
      chk_status("rand");
    end

    // Asynchronous reset between edges
    en = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("async_reset");
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk_status("post_reset");

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("valid_pulses", 32'(pulses_seen), 32'(strobes_sent));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
